// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: mode encodings and
// the legality check used to flag reserved operations.
package shifter_pkg;

  localparam logic [2:0] MODE_SLL = 3'b000;
  localparam logic [2:0] MODE_SRL = 3'b001;
  localparam logic [2:0] MODE_SRA = 3'b010;
  localparam logic [2:0] MODE_ROL = 3'b011;
  localparam logic [2:0] MODE_ROR = 3'b100;

  function automatic logic is_legal_mode(input logic [2:0] mode);
    is_legal_mode = (mode <= MODE_ROR);
  endfunction

endpackage

// File: rtl/shifter_stage.sv
// One pipeline stage: conditionally shifts/rotates by AMT when the matching
// shift-amount bit is set, then registers the item with hold-on-stall.
module shifter_stage
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int AMT   = 1,
  localparam int SHW  = $clog2(WIDTH),
  localparam int IDX  = $clog2(AMT)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             stall_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [SHW-1:0]   shamt_i,
  input  logic [2:0]       mode_i,
  input  logic             illegal_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [SHW-1:0]   shamt_o,
  output logic [2:0]       mode_o,
  output logic             illegal_o
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic [SHW-1:0]   shamt_q;
  logic [2:0]       mode_q;
  logic             illegal_q;

  // Reserved modes bypass the shifter so the operand emerges untouched
  always_comb begin
    data_d = data_i;
    if (shamt_i[IDX] && !illegal_i) begin
      case (mode_i)
        MODE_SLL: data_d = data_i << AMT;
        MODE_SRL: data_d = data_i >> AMT;
        MODE_SRA: data_d = $unsigned($signed(data_i) >>> AMT);
        MODE_ROL: data_d = (data_i << AMT) | (data_i >> (WIDTH - AMT));
        MODE_ROR: data_d = (data_i >> AMT) | (data_i << (WIDTH - AMT));
        default:  data_d = data_i;
      endcase
    end else begin
      data_d = data_i;
    end
  end

  // Stage register: cleared by reset, frozen while the output is stalled
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q   <= 1'b0;
      data_q    <= {WIDTH{1'b0}};
      shamt_q   <= {SHW{1'b0}};
      mode_q    <= 3'b000;
      illegal_q <= 1'b0;
    end else if (!stall_i) begin
      valid_q   <= valid_i;
      data_q    <= data_d;
      shamt_q   <= shamt_i;
      mode_q    <= mode_i;
      illegal_q <= illegal_i;
    end
  end

  assign valid_o   = valid_q;
  assign data_o    = data_q;
  assign shamt_o   = shamt_q;
  assign mode_o    = mode_q;
  assign illegal_o = illegal_q;

endmodule

// File: rtl/shifter_pipe.sv
// Pipelined barrel shifter: one stage per shift-amount bit, with a global
// stall that freezes every stage while the consumer is not ready.
module shifter_pipe
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int SHW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [2:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_illegal
);

  logic             valid_s   [SHW+1];
  logic [WIDTH-1:0] data_s    [SHW+1];
  logic [SHW-1:0]   shamt_s   [SHW+1];
  logic [2:0]       mode_s    [SHW+1];
  logic             illegal_s [SHW+1];
  logic             stall_s;

  // Bubbles are not squeezed out, so any held output blocks the whole pipe
  assign stall_s  = valid_s[SHW] && !out_ready;
  assign in_ready = !stall_s;

  assign valid_s[0]   = in_valid && in_ready;
  assign data_s[0]    = in_data;
  assign shamt_s[0]   = in_shamt;
  assign mode_s[0]    = in_mode;
  assign illegal_s[0] = !is_legal_mode(in_mode);

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    shifter_stage #(
      .WIDTH (WIDTH),
      .AMT   (1 << k)
    ) u_stage (
      .clk       (clk),
      .reset_n   (reset_n),
      .stall_i   (stall_s),
      .valid_i   (valid_s[k]),
      .data_i    (data_s[k]),
      .shamt_i   (shamt_s[k]),
      .mode_i    (mode_s[k]),
      .illegal_i (illegal_s[k]),
      .valid_o   (valid_s[k+1]),
      .data_o    (data_s[k+1]),
      .shamt_o   (shamt_s[k+1]),
      .mode_o    (mode_s[k+1]),
      .illegal_o (illegal_s[k+1])
    );
  end

  assign out_valid   = valid_s[SHW];
  assign out_data    = data_s[SHW];
  assign out_illegal = illegal_s[SHW];

endmodule

// File: tb/tb_shifter_pipe.sv
// Directed bench for shifter_pipe (WIDTH=32): mode vectors, latency,
// back-pressure ordering/stability and mid-stream reset.
module tb_shifter_pipe;

  localparam int WIDTH = 32;
  localparam int SHW   = 5;

  localparam logic [2:0] M_SLL = 3'b000;
  localparam logic [2:0] M_SRL = 3'b001;
  localparam logic [2:0] M_SRA = 3'b010;
  localparam logic [2:0] M_ROL = 3'b011;
  localparam logic [2:0] M_ROR = 3'b100;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_shamt;
  logic [2:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_illegal;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  shifter_pipe #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_shamt    (in_shamt),
    .in_mode     (in_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_illegal (out_illegal)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Present one item, then require it to appear exactly SHW cycles later
  task automatic run_one(input string tag, input logic [2:0] mode, input logic [31:0] data,
                         input logic [4:0] shamt, input logic [31:0] exp, input logic exp_ill);
    in_valid = 1'b1;
    in_mode  = mode;
    in_data  = data;
    in_shamt = shamt;
    tick();
    in_valid = 1'b0;
    in_data  = 32'hDEAD_BEEF;
    repeat (3) tick();
    check({tag, "_early"}, 64'(out_valid), 64'd0);
    tick();
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_data"}, 64'(out_data), 64'(exp));
    check({tag, "_ill"}, 64'(out_illegal), 64'(exp_ill));
    tick();
  endtask

  initial begin
    logic [31:0] exp_q[$];
    int pushed;
    int popped;
    logic stall_win;

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = 32'h0;
    in_shamt  = 5'd0;
    in_mode   = 3'b000;
    out_ready = 1'b1;
    tick();
    tick();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_ill", 64'(out_illegal), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    reset_n = 1'b1;
    tick();

    run_one("sll2",     M_SLL, 32'h0000_0001, 5'd2,  32'h0000_0004, 1'b0);
    run_one("sra31",    M_SRA, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b0);
    run_one("srl31",    M_SRL, 32'h8000_0000, 5'd31, 32'h0000_0001, 1'b0);
    run_one("ror1",     M_ROR, 32'h0000_0001, 5'd1,  32'h8000_0000, 1'b0);
    run_one("rol4",     M_ROL, 32'h8000_0001, 5'd4,  32'h0000_0018, 1'b0);
    run_one("rsv110",   3'b110, 32'h1234_5678, 5'd7, 32'h1234_5678, 1'b1);
    run_one("rsv111",   3'b111, 32'hCAFE_0001, 5'd0, 32'hCAFE_0001, 1'b1);
    run_one("sll0",     M_SLL, 32'h89AB_CDEF, 5'd0,  32'h89AB_CDEF, 1'b0);
    run_one("rol8",     M_ROL, 32'h1234_5678, 5'd8,  32'h3456_7812, 1'b0);
    run_one("srl4",     M_SRL, 32'hF000_0000, 5'd4,  32'h0F00_0000, 1'b0);
    run_one("sra4_pos", M_SRA, 32'h7000_0000, 5'd4,  32'h0700_0000, 1'b0);
    run_one("ror16",    M_ROR, 32'hABCD_1234, 5'd16, 32'h1234_ABCD, 1'b0);

    // Back-pressure: item i is (0x100+i) << i; consumer refuses cycles 7..9,
    // when item 2 sits at the output.
    for (int i = 0; i < 8; i++) exp_q.push_back((32'h100 + 32'(i)) << i);
    pushed = 0;
    popped = 0;
    for (int c = 0; c < 40 && popped < 8; c++) begin
      stall_win = (c >= 7 && c <= 9);
      out_ready = !stall_win;
      in_valid  = (pushed < 8);
      in_mode   = M_SLL;
      in_data   = 32'h100 + 32'(pushed);
      in_shamt  = 5'(pushed);
      #1;
      check("bp_in_ready", 64'(in_ready), 64'(!stall_win));
      if (out_valid) begin
        check("bp_data", 64'(out_data), 64'(exp_q[popped]));
        check("bp_ill", 64'(out_illegal), 64'd0);
        if (out_ready) popped++;
      end
      if (in_valid && in_ready) pushed++;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp_pushed", 64'(pushed), 64'd8);
    check("bp_popped", 64'(popped), 64'd8);
    repeat (2) tick();
    check("bp_drained", 64'(out_valid), 64'd0);

    // Mid-stream reset with three items in flight
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_mode  = M_ROL;
      in_data  = 32'hA5A5_0000 + 32'(i);
      in_shamt = 5'd3;
      tick();
    end
    in_valid = 1'b0;
    reset_n  = 1'b0;
    tick();
    check("mrst_out_valid", 64'(out_valid), 64'd0);
    check("mrst_out_data", 64'(out_data), 64'd0);
    check("mrst_out_ill", 64'(out_illegal), 64'd0);
    check("mrst_in_ready", 64'(in_ready), 64'd1);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("mrst_no_stale", 64'(out_valid), 64'd0);
    end
    run_one("post_rst", M_SLL, 32'h0000_0003, 5'd5, 32'h0000_0060, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
